// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end sharing one combinational ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  input  logic [3:0]       req0_ctrl_i,
  input  logic [3:0]       req1_ctrl_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             resp0_valid_o,
  output logic             resp1_valid_o,
  input  logic             resp0_ready_i,
  input  logic             resp1_ready_i,
  output logic [WIDTH-1:0] resp_data_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic             win1, hs;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  // ptr_q names the requester preferred on a tie: the one not granted last
  assign win1 = req1_valid_i & (~req0_valid_i | ptr_q);
  always_comb ptr_d = hs ? ~win1 : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
`else
  assign win1 = req1_valid_i & ~req0_valid_i;
`endif
  assign req0_ready_o  = state_q == IDLE & req0_valid_i & ~win1;
  assign req1_ready_o  = state_q == IDLE & win1;
  assign hs            = req0_ready_o | req1_ready_o;
  assign resp0_valid_o = state_q == RESP & ~grant_q;
  assign resp1_valid_o = state_q == RESP & grant_q;
  assign resp_data_o   = data_q;
  assign alu_ctrl_o    = ctrl_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = EXEC;
        grant_d = win1;
        ctrl_d  = win1 ? req1_ctrl_i : req0_ctrl_i;
        a_d     = win1 ? req1_a_i : req0_a_i;
        b_d     = win1 ? req1_b_i : req0_b_i;
      end
      EXEC: begin
        state_d = RESP;
        data_d  = alu_result_i;
      end
      RESP: state_d = (grant_q ? resp1_ready_i : resp0_ready_i) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ctrl_q  <= 4'b0000;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU stand-in.
module tb_alu_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0_valid_i = 0, req1_valid_i = 0, req0_ready_o, req1_ready_o;
  logic [3:0]  req0_ctrl_i = 0, req1_ctrl_i = 0, alu_ctrl_o;
  logic [31:0] req0_a_i = 0, req0_b_i = 0, req1_a_i = 0, req1_b_i = 0;
  logic        resp0_valid_o, resp1_valid_o, resp0_ready_i = 0, resp1_ready_i = 0;
  logic [31:0] resp_data_o, alu_a_o, alu_b_o, alu_result_i;
  int vec = 0, miss = 0;
  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .req0_ctrl_i(req0_ctrl_i), .req1_ctrl_i(req1_ctrl_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .resp0_valid_o(resp0_valid_o), .resp1_valid_o(resp1_valid_o),
    .resp0_ready_i(resp0_ready_i), .resp1_ready_i(resp1_ready_i),
    .resp_data_o(resp_data_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_result_i(alu_result_i)
  );
  always #5 clk = ~clk;
  always_comb alu_result_i = alu_ctrl_o == 4'b0000 ? alu_a_o + alu_b_o :
                             alu_ctrl_o == 4'b0011 ? {31'b0, alu_a_o < alu_b_o} : alu_a_o ^ alu_b_o;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int g, n;
    logic [31:0] exp_g;
    #2;
    chk("rst_ready", {30'b0, req0_ready_o, req1_ready_o}, 0);
    chk("rst_resp_valid", {30'b0, resp0_valid_o, resp1_valid_o}, 0);
    chk("rst_data", resp_data_o, 0);
    chk("rst_alu", {alu_ctrl_o, alu_a_o[27:0] | alu_b_o[27:0]}, 0);
    step();
    rst = 0;
    // single req0 ADD 5+7
    req0_valid_i = 1; req0_ctrl_i = 4'b0000; req0_a_i = 5; req0_b_i = 7; resp0_ready_i = 1;
    #1 chk("s1_ready0", {31'b0, req0_ready_o}, 1);
    step();
    req0_valid_i = 0;
    chk("s1_exec_ready0", {31'b0, req0_ready_o}, 0);
    chk("s1_alu_a", alu_a_o, 5);
    chk("s1_alu_b", alu_b_o, 7);
    chk("s1_resp_early", {31'b0, resp0_valid_o}, 0);
    step();
    chk("s1_resp0_valid", {31'b0, resp0_valid_o}, 1);
    chk("s1_data", resp_data_o, 12);
    chk("s1_resp1_valid", {31'b0, resp1_valid_o}, 0);
    step();
    chk("s1_done", {31'b0, resp0_valid_o}, 0);
    chk("s1_alu_hold", alu_a_o, 5);
    // req1 SLTU 3<9 with a stalled consumer; req0's resp_ready must be ignored
    req1_valid_i = 1; req1_ctrl_i = 4'b0011; req1_a_i = 3; req1_b_i = 9;
    step();
    req1_valid_i = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("s2_resp1_valid", {31'b0, resp1_valid_o}, 1);
      chk("s2_data", resp_data_o, 1);
      chk("s2_resp0_valid", {31'b0, resp0_valid_o}, 0);
      step();
    end
    resp1_ready_i = 1;
    #1 chk("s2_last", {31'b0, resp1_valid_o}, 1);
    step();
    chk("s2_done", {31'b0, resp1_valid_o}, 0);
    // both requesters valid continuously
    req0_valid_i = 1; req0_ctrl_i = 0; req0_a_i = 10;  req0_b_i = 20;
    req1_valid_i = 1; req1_ctrl_i = 0; req1_a_i = 100; req1_b_i = 1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready_o || req1_ready_o) && n < 10) begin step(); n++; end
      chk("s3_wait", n < 10 ? 32'd1 : 32'd0, 1);
      chk("s3_excl", {31'b0, req0_ready_o & req1_ready_o}, 0);
      g = req1_ready_o ? 1 : 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      chk("s3_grant", g, exp_g);
      step();
      chk("s3_exec_ready", {30'b0, req0_ready_o, req1_ready_o}, 0);
      step();
      chk("s3_resp_valid", {30'b0, resp1_valid_o, resp0_valid_o}, g ? 2 : 1);
      chk("s3_data", resp_data_o, g ? 101 : 30);
      step();
    end
    req0_valid_i = 0; req1_valid_i = 0;
    #1;
    // async reset during RESP of a req0 op
    resp0_ready_i = 0;
    req0_valid_i = 1; req0_a_i = 1; req0_b_i = 2; req0_ctrl_i = 4'b0111;
    step();
    req0_valid_i = 0;
    step();
    chk("s4_resp_before", {31'b0, resp0_valid_o}, 1);
    chk("s4_data_before", resp_data_o, 3);
    #1 rst = 1;
    #1;
    chk("s4_resp_async", {30'b0, resp0_valid_o, resp1_valid_o}, 0);
    chk("s4_data_async", resp_data_o, 0);
    chk("s4_alu_async", alu_a_o | alu_b_o | {28'b0, alu_ctrl_o}, 0);
    resp0_ready_i = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("s4_no_resp", {31'b0, resp0_valid_o}, 0);
      step();
    end
    // req1 arrives while a full-width req0 op executes
    req0_valid_i = 1; req0_ctrl_i = 0; req0_a_i = 32'h8000_0000; req0_b_i = 32'h7FFF_FFFF;
    step();
    req0_valid_i = 0;
    req1_valid_i = 1; req1_ctrl_i = 4'b0011; req1_a_i = 2; req1_b_i = 8; resp1_ready_i = 1;
    #1 chk("s5_exec_ready1", {31'b0, req1_ready_o}, 0);
    step();
    chk("s5_resp_ready1", {31'b0, req1_ready_o}, 0);
    chk("s5_resp0", {31'b0, resp0_valid_o}, 1);
    chk("s5_data0", resp_data_o, 32'hFFFF_FFFF);
    step();
    chk("s5_idle_ready1", {31'b0, req1_ready_o}, 1);
    step();
    req1_valid_i = 0;
    step();
    chk("s5_resp1", {31'b0, resp1_valid_o}, 1);
    chk("s5_data1", resp_data_o, 1);
    step();
    chk("s5_done", {31'b0, resp1_valid_o}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
